frame_scheduler: RTL and testbench
==================================

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter H_RES, default 640, horizontal pixels per frame.
REQ-002 Parameter V_RES, default 480, vertical lines per frame.
REQ-003 Parameter ADDR_W, default 19, framebuffer word-address width.
REQ-004 Parameter COLOR_W, default 6, pixel colour width.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 frame_start  in  1  request to render one frame; sampled only in IDLE.
REQ-008 clear_color  in  COLOR_W  fill colour, sampled every CLEAR cycle.
REQ-009 vsync  in  1  one-cycle pulse at start of vertical blank.
REQ-010 fifo_empty  in  1  triangle command FIFO empty.
REQ-011 rast_start  out  1  one-cycle pulse launching the rasterizer.
REQ-012 rast_done  in  1  rasterizer idle/finished.
REQ-013 rast_addr  in  ADDR_W, rast_data  in  COLOR_W, rast_wen  in  1: rasterizer write request.
REQ-014 fb_addr  out  ADDR_W, fb_data  out  COLOR_W, fb_wen  out  1: registered framebuffer write port.
REQ-015 fb_sel  out  1  back buffer being written; disp_sel  out  1  front buffer being scanned.
REQ-016 frame_done  out  1  high while in IDLE.

Function
REQ-017 States IDLE, CLEAR, DRAW, WAIT_VSYNC; frame_start while not in IDLE SHALL be ignored.
REQ-018 IDLE: fb_wen=0; frame_start=1 -> CLEAR with clear counter=0.
REQ-019 CLEAR: each cycle, write clear_color to counter address, counter+1; after the write to address H_RES*V_RES-1 (307199) -> DRAW.
REQ-020 Framebuffer outputs SHALL be registered: a write selected in cycle N appears on fb_* in cycle N+1.
REQ-021 rast_start SHALL be 1 for exactly the first DRAW cycle, otherwise 0.
REQ-022 DRAW: fb_* SHALL forward rast_addr/rast_data/rast_wen with one-cycle latency.
REQ-023 rast_wen with rast_addr >= H_RES*V_RES SHALL be dropped (fb_wen=0).
REQ-024 rast_wen outside DRAW SHALL be dropped.
REQ-025 rast_done SHALL be ignored in the first two DRAW cycles.
REQ-026 From the third DRAW cycle on, rast_done=1 and fifo_empty=1 in the same cycle -> WAIT_VSYNC; a rast_wen in that cycle SHALL still be forwarded.
REQ-027 WAIT_VSYNC: fb_wen=0; vsync=1 -> toggle disp_sel, -> IDLE. vsync outside WAIT_VSYNC SHALL be ignored.
REQ-028 fb_sel SHALL equal ~disp_sel at all times.
REQ-029 Clear counter SHALL be ADDR_W bits wide and SHALL not wrap: it stops at 307199.

Reset
REQ-030 While reset=0: state=IDLE, counter=0, disp_sel=0, fb_sel=1, rast_start=0, fb_wen=0, fb_addr=0, fb_data=0, frame_done=1.
REQ-031 Reset asserted mid-CLEAR or mid-DRAW SHALL abort the frame immediately; no further fb_wen until the next frame_start after release.

Structure
REQ-032 Shared package gpu_pkg SHALL hold H_RES, V_RES, FB_WORDS (=H_RES*V_RES), ADDR_W, COLOR_W and the state encoding.
REQ-033 The clear address generator SHALL be sub-module fb_clear_gen (counter, enable, last flag).

Verification
REQ-034 Reset release, frame_start pulse, clear_color=6'h15 -> 307200 consecutive fb_wen cycles, addresses 0..307199 at data 6'h15, fb_sel=1; then rast_start pulse for one cycle.
REQ-035 In DRAW, rast_wen=1, addr=1000, data=6'h3F -> next cycle fb_wen=1, fb_addr=1000, fb_data=6'h3F; addr=307200 -> fb_wen=0.
REQ-036 rast_done=1 held from first DRAW cycle, fifo_empty=1 -> no exit in DRAW cycles 1-2; WAIT_VSYNC entered after cycle 3.
REQ-037 In WAIT_VSYNC, vsync pulse -> disp_sel 0->1, fb_sel 1->0, frame_done=1 next cycle; vsync during DRAW -> no toggle.
REQ-038 frame_start during CLEAR -> ignored, counter unaffected; reset=0 at clear address 5000 -> fb_wen=0, state IDLE, disp_sel=0.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared frame-scheduler constants and state encoding.
// Module parameters default to these values so all blocks agree on geometry.
package gpu_pkg;

    localparam int unsigned H_RES    = 640;
    localparam int unsigned V_RES    = 480;
    localparam int unsigned FB_WORDS = H_RES * V_RES;
    localparam int unsigned ADDR_W   = 19;
    localparam int unsigned COLOR_W  = 6;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StDraw,
        StWaitVsync
    } fs_state_e;

endpackage

// File: rtl/fb_clear_gen.sv
// Clear-pass address generator: saturating word counter with a last-address flag.
// The counter holds at the final address instead of wrapping.
module fb_clear_gen #(
    parameter int unsigned ADDR_W   = gpu_pkg::ADDR_W,
    parameter int unsigned FB_WORDS = gpu_pkg::FB_WORDS
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FB_WORDS - 1);

    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LastAddr)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == LastAddr);

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: clears the back buffer, hands it to the rasterizer,
// then swaps buffers on the next vertical blank.
module frame_scheduler #(
    parameter int unsigned H_RES   = gpu_pkg::H_RES,
    parameter int unsigned V_RES   = gpu_pkg::V_RES,
    parameter int unsigned ADDR_W  = gpu_pkg::ADDR_W,
    parameter int unsigned COLOR_W = gpu_pkg::COLOR_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               frame_start_i,
    input  logic [COLOR_W-1:0] clear_color_i,
    input  logic               vsync_i,
    input  logic               fifo_empty_i,
    output logic               rast_start_o,
    input  logic               rast_done_i,
    input  logic [ADDR_W-1:0]  rast_addr_i,
    input  logic [COLOR_W-1:0] rast_data_i,
    input  logic               rast_wen_i,
    output logic [ADDR_W-1:0]  fb_addr_o,
    output logic [COLOR_W-1:0] fb_data_o,
    output logic               fb_wen_o,
    output logic               fb_sel_o,
    output logic               disp_sel_o,
    output logic               frame_done_o
);

    import gpu_pkg::*;

    localparam int unsigned     FbWords  = H_RES * V_RES;
    localparam logic [ADDR_W:0] FbWordsW = (ADDR_W + 1)'(FbWords);

    fs_state_e          state_q, state_d;
    logic [1:0]         draw_cnt_q, draw_cnt_d;
    logic               disp_sel_q, disp_sel_d;
    logic               fb_wen_q, fb_wen_d;
    logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
    logic [COLOR_W-1:0] fb_data_q, fb_data_d;

    logic              clr_clr, clr_en, clr_last;
    logic [ADDR_W-1:0] clr_cnt;
    logic              rast_in_range;

    fb_clear_gen #(
        .ADDR_W   (ADDR_W),
        .FB_WORDS (FbWords)
    ) u_clear_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_clr),
        .en_i   (clr_en),
        .cnt_o  (clr_cnt),
        .last_o (clr_last)
    );

    assign rast_in_range = ({1'b0, rast_addr_i} < FbWordsW);

    always_comb begin
        state_d    = state_q;
        draw_cnt_d = draw_cnt_q;
        disp_sel_d = disp_sel_q;
        fb_wen_d   = 1'b0;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        clr_clr    = 1'b0;
        clr_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                clr_clr    = 1'b1;
                draw_cnt_d = 2'd0;
                if (frame_start_i) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                clr_en     = 1'b1;
                fb_wen_d   = 1'b1;
                fb_addr_d  = clr_cnt;
                fb_data_d  = clear_color_i;
                draw_cnt_d = 2'd0;
                if (clr_last) begin
                    state_d = StDraw;
                end
            end
            StDraw: begin
                if (draw_cnt_q != 2'd2) begin
                    draw_cnt_d = draw_cnt_q + 2'd1;
                end
                if (rast_wen_i && rast_in_range) begin
                    fb_wen_d  = 1'b1;
                    fb_addr_d = rast_addr_i;
                    fb_data_d = rast_data_i;
                end
                // rast_done may be stale from the previous frame for two cycles
                if ((draw_cnt_q == 2'd2) && rast_done_i && fifo_empty_i) begin
                    state_d = StWaitVsync;
                end
            end
            StWaitVsync: begin
                if (vsync_i) begin
                    disp_sel_d = ~disp_sel_q;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            draw_cnt_q <= 2'd0;
            disp_sel_q <= 1'b0;
            fb_wen_q   <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            draw_cnt_q <= draw_cnt_d;
            disp_sel_q <= disp_sel_d;
            fb_wen_q   <= fb_wen_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
        end
    end

    assign rast_start_o = (state_q == StDraw) && (draw_cnt_q == 2'd0);
    assign fb_wen_o     = fb_wen_q;
    assign fb_addr_o    = fb_addr_q;
    assign fb_data_o    = fb_data_q;
    assign disp_sel_o   = disp_sel_q;
    assign fb_sel_o     = ~disp_sel_q;
    assign frame_done_o = (state_q == StIdle);

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler on a reduced 80x64 frame (5120 words).
module tb_frame_scheduler;

    localparam int unsigned H  = 80;
    localparam int unsigned V  = 64;
    localparam int unsigned AW = 19;
    localparam int unsigned CW = 6;
    localparam int unsigned FB = H * V;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic [CW-1:0] clear_color;
    logic          vsync;
    logic          fifo_empty;
    logic          rast_start;
    logic          rast_done;
    logic [AW-1:0] rast_addr;
    logic [CW-1:0] rast_data;
    logic          rast_wen;
    logic [AW-1:0] fb_addr;
    logic [CW-1:0] fb_data;
    logic          fb_wen;
    logic          fb_sel;
    logic          disp_sel;
    logic          frame_done;

    int errors = 0;
    int checks = 0;

    frame_scheduler #(
        .H_RES   (H),
        .V_RES   (V),
        .ADDR_W  (AW),
        .COLOR_W (CW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .frame_start_i (frame_start),
        .clear_color_i (clear_color),
        .vsync_i       (vsync),
        .fifo_empty_i  (fifo_empty),
        .rast_start_o  (rast_start),
        .rast_done_i   (rast_done),
        .rast_addr_i   (rast_addr),
        .rast_data_i   (rast_data),
        .rast_wen_i    (rast_wen),
        .fb_addr_o     (fb_addr),
        .fb_data_o     (fb_data),
        .fb_wen_o      (fb_wen),
        .fb_sel_o      (fb_sel),
        .disp_sel_o    (disp_sel),
        .frame_done_o  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_start = 1'b0; clear_color = '0; vsync = 1'b0;
        fifo_empty = 1'b0; rast_done = 1'b0; rast_addr = '0; rast_data = '0; rast_wen = 1'b0;
        tick(); tick();
        checks++;
        if ({fb_wen, fb_addr, fb_data} !== '0) begin
            errors++;
            $display("FAIL reset_fb: wen=%0b addr=%0d data=%0h, want 0/0/0", fb_wen, fb_addr, fb_data);
        end
        checks++;
        if ({disp_sel, fb_sel, rast_start, frame_done} !== 4'b0101) begin
            errors++;
            $display("FAIL reset_ctl: disp=%0b fbsel=%0b rstart=%0b done=%0b, want 0 1 0 1",
                     disp_sel, fb_sel, rast_start, frame_done);
        end
        rst_n = 1'b1;
        tick();
        vsync = 1'b1; rast_wen = 1'b1; rast_addr = AW'(3); rast_data = CW'(6'h09);
        tick();
        vsync = 1'b0; rast_wen = 1'b0;
        checks++;
        if ({fb_wen, disp_sel, frame_done} !== 3'b001) begin
            errors++;
            $display("FAIL idle_ignore: wen=%0b disp=%0b done=%0b, want 0 0 1",
                     fb_wen, disp_sel, frame_done);
        end
    endtask

    task automatic test_clear_sweep();
        int bad = 0;
        int first_bad = -1;
        int rs_bad = 0;
        clear_color = CW'(6'h15);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++;
        if ({fb_wen, frame_done} !== 2'b00) begin
            errors++;
            $display("FAIL clear_entry: wen=%0b done=%0b, want 0 0", fb_wen, frame_done);
        end
        for (int i = 0; i < int'(FB); i++) begin
            tick();
            if (fb_wen !== 1'b1 || fb_addr !== AW'(i) || fb_data !== CW'(6'h15) ||
                fb_sel !== 1'b1 || frame_done !== 1'b0) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
            if (rast_start !== (i == int'(FB) - 1)) rs_bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_sweep: %0d bad cycles, first at index %0d, want 0", bad, first_bad);
        end
        checks++;
        if (rs_bad != 0) begin
            errors++;
            $display("FAIL clear_rast_start: %0d wrong cycles, want pulse only on first DRAW cycle",
                     rs_bad);
        end
    endtask

    task automatic test_draw_forward();
        rast_wen = 1'b1; rast_addr = AW'(1000); rast_data = CW'(6'h3F);
        tick();
        checks++;
        if ({fb_wen, fb_addr, fb_data, rast_start} !== {1'b1, AW'(1000), CW'(6'h3F), 1'b0}) begin
            errors++;
            $display("FAIL draw_fwd: wen=%0b addr=%0d data=%0h rstart=%0b, want 1 1000 3f 0",
                     fb_wen, fb_addr, fb_data, rast_start);
        end
        rast_addr = AW'(FB); rast_data = CW'(6'h11); vsync = 1'b1;
        tick();
        vsync = 1'b0;
        checks++;
        if ({fb_wen, disp_sel} !== 2'b00) begin
            errors++;
            $display("FAIL draw_oob_vsync: wen=%0b disp=%0b, want 0 0", fb_wen, disp_sel);
        end
        rast_addr = AW'(FB - 1); rast_data = CW'(6'h2A); rast_done = 1'b1; fifo_empty = 1'b0;
        tick();
        checks++;
        if ({fb_wen, fb_addr, fb_data} !== {1'b1, AW'(FB - 1), CW'(6'h2A)}) begin
            errors++;
            $display("FAIL draw_top_addr: wen=%0b addr=%0d data=%0h, want 1 %0d 2a",
                     fb_wen, fb_addr, fb_data, FB - 1);
        end
        rast_addr = AW'(7); rast_data = CW'(6'h01); fifo_empty = 1'b1;
        tick();
        checks++;
        if ({fb_wen, fb_addr, fb_data} !== {1'b1, AW'(7), CW'(6'h01)}) begin
            errors++;
            $display("FAIL draw_exit_fwd: wen=%0b addr=%0d data=%0h, want 1 7 01",
                     fb_wen, fb_addr, fb_data);
        end
        rast_addr = AW'(8);
        tick();
        checks++;
        if ({fb_wen, frame_done} !== 2'b00) begin
            errors++;
            $display("FAIL wait_drop: wen=%0b done=%0b, want 0 0", fb_wen, frame_done);
        end
        rast_wen = 1'b0; rast_done = 1'b0; fifo_empty = 1'b0; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; vsync = 1'b1;
        tick();
        vsync = 1'b0;
        checks++;
        if ({disp_sel, fb_sel, frame_done} !== 3'b101) begin
            errors++;
            $display("FAIL vsync_swap: disp=%0b fbsel=%0b done=%0b, want 1 0 1",
                     disp_sel, fb_sel, frame_done);
        end
        tick();
        checks++;
        if ({fb_wen, frame_done} !== 2'b01) begin
            errors++;
            $display("FAIL wait_start_ignored: wen=%0b done=%0b, want 0 1", fb_wen, frame_done);
        end
    endtask

    task automatic test_start_ignored_and_abort();
        int bad = 0;
        int leak = 0;
        clear_color = CW'(6'h2B);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i <= 5000; i++) begin
            tick();
            if (fb_wen !== 1'b1 || fb_addr !== AW'(i) || fb_data !== CW'(6'h2B)) bad++;
            frame_start = (i == 100);
        end
        frame_start = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_restart_ignored: %0d bad cycles, want 0", bad);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fb_wen, fb_addr, frame_done, disp_sel, fb_sel} !== {1'b0, AW'(0), 3'b101}) begin
            errors++;
            $display("FAIL abort_reset: wen=%0b addr=%0d done=%0b disp=%0b fbsel=%0b, want 0 0 1 0 1",
                     fb_wen, fb_addr, frame_done, disp_sel, fb_sel);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (fb_wen !== 1'b0 || frame_done !== 1'b1) leak++;
        end
        checks++;
        if (leak != 0) begin
            errors++;
            $display("FAIL abort_no_writes: %0d cycles with writes or not idle, want 0", leak);
        end
    endtask

    task automatic test_done_window();
        bit found = 1'b0;
        clear_color = CW'(6'h01);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < int'(FB) + 8; i++) begin
            tick();
            if (rast_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL draw_reach: rast_start=%0b after budget, want 1", rast_start);
        end
        rast_done = 1'b1; fifo_empty = 1'b1; rast_wen = 1'b1; rast_data = CW'(6'h05);
        for (int c = 0; c < 4; c++) begin
            rast_addr = AW'(10 + c);
            tick();
            checks++;
            if (c < 3) begin
                if ({fb_wen, fb_addr} !== {1'b1, AW'(10 + c)}) begin
                    errors++;
                    $display("FAIL done_window_c%0d: wen=%0b addr=%0d, want 1 %0d",
                             c + 1, fb_wen, fb_addr, 10 + c);
                end
            end else if (fb_wen !== 1'b0) begin
                errors++;
                $display("FAIL done_window_exit: wen=%0b, want 0", fb_wen);
            end
        end
        rast_wen = 1'b0; rast_done = 1'b0; fifo_empty = 1'b0; vsync = 1'b1;
        tick();
        vsync = 1'b0;
        checks++;
        if ({disp_sel, fb_sel, frame_done} !== 3'b101) begin
            errors++;
            $display("FAIL done_window_swap: disp=%0b fbsel=%0b done=%0b, want 1 0 1",
                     disp_sel, fb_sel, frame_done);
        end
    endtask

    initial begin
        test_reset();
        test_clear_sweep();
        test_draw_forward();
        test_start_ignored_and_abort();
        test_done_window();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
